// File: rtl/ps2_rx_buffered_pkg.sv
// Shared PS/2 receive definitions: frame constants, receiver FSM states and the parity helper.
package ps2_rx_buffered_pkg;

  localparam int   PS2_FRAME_DATA_BITS = 8;
  localparam logic PS2_START_BIT       = 1'b0;
  localparam logic PS2_STOP_BIT        = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } ps2_state_t;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [PS2_FRAME_DATA_BITS-1:0] i_data,
                                         input logic i_par);
    return ^{i_data, i_par};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head output.
// Full/empty come from the occupancy count; pointers wrap modulo DEPTH (power of 2).
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;

  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_rd_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign w_do_pop = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign w_rd_nxt  = r_rd_ptr + 1'b1;

  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_cnt_nxt = r_count + 1'b1;
      2'b01:   w_cnt_nxt = r_count - 1'b1;
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= w_rd_nxt;
      r_count <= w_cnt_nxt;
      // The head register follows whichever entry will be at the read pointer next cycle.
      if (w_cnt_nxt == '0)
        r_dout <= '0;
      else if (w_do_push && (o_empty || (r_count == CW'(1) && w_do_pop)))
        r_dout <= i_din;
      else if (w_do_pop)
        r_dout <= r_mem[w_rd_nxt];
    end
  end

  assign o_dout  = r_dout;
  assign o_count = r_count;

endmodule

// File: rtl/ps2_rx_buffered.sv
// PS/2 device-to-host receiver: pin synchronisers, glitch filter, frame FSM with inter-bit
// timeout, per-cause error pulses, and a FWFT byte FIFO towards the consumer.
module ps2_rx_buffered
  import ps2_rx_buffered_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sync_reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  output logic [7:0]                    data_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          framing_err,
  output logic                          timeout_err,
  output logic                          overflow_err,
  output ps2_state_t                    dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  // Input conditioning: 2-flop synchroniser, then a level filter per pin.
  logic [1:0]            r_clk_sync, r_dat_sync;
  logic [FILTER_LEN-1:0] r_clk_hist, r_dat_hist;
  logic                  r_clk_f, r_dat_f, r_clk_f_q;
  logic                  w_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_hist <= '1;
      r_dat_hist <= '1;
      r_clk_f    <= 1'b1;
      r_dat_f    <= 1'b1;
      r_clk_f_q  <= 1'b1;
    end else if (sync_reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_hist <= '1;
      r_dat_hist <= '1;
      r_clk_f    <= 1'b1;
      r_dat_f    <= 1'b1;
      r_clk_f_q  <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_dat};
      r_clk_hist <= {r_clk_hist[FILTER_LEN-2:0], r_clk_sync[1]};
      r_dat_hist <= {r_dat_hist[FILTER_LEN-2:0], r_dat_sync[1]};
      if (&r_clk_hist)       r_clk_f <= 1'b1;
      else if (~|r_clk_hist) r_clk_f <= 1'b0;
      if (&r_dat_hist)       r_dat_f <= 1'b1;
      else if (~|r_dat_hist) r_dat_f <= 1'b0;
      r_clk_f_q <= r_clk_f;
    end
  end

  assign w_fall = r_clk_f_q & ~r_clk_f;

  // Frame FSM, timeout counter and registered error/push strobes.
  ps2_state_t                     r_state;
  logic [2:0]                     r_bit_cnt;
  logic [PS2_FRAME_DATA_BITS-1:0] r_shift;
  logic                           r_par;
  logic [TO_W-1:0]                r_to_cnt;
  logic                           r_push_req;
  logic [PS2_FRAME_DATA_BITS-1:0] r_push_data;
  logic                           r_parity_err, r_framing_err, r_timeout_err;
  logic                           w_to_hit;

  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_to_cnt      <= '0;
      r_push_req    <= 1'b0;
      r_push_data   <= '0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (sync_reset) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_to_cnt      <= '0;
      r_push_req    <= 1'b0;
      r_push_data   <= '0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_push_req    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_timeout_err <= 1'b0;

      if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
      else                             r_to_cnt <= r_to_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          r_bit_cnt <= '0;
          if (w_fall && r_dat_f == PS2_START_BIT) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_fall) begin
            r_shift   <= {r_dat_f, r_shift[PS2_FRAME_DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'(PS2_FRAME_DATA_BITS - 1)) r_state <= S_PARITY;
          end else if (w_to_hit) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        S_PARITY: begin
          if (w_fall) begin
            r_par   <= r_dat_f;
            r_state <= S_STOP;
          end else if (w_to_hit) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        S_STOP: begin
          if (w_fall) begin
            r_state <= S_IDLE;
            if (!ps2_parity_ok(r_shift, r_par)) begin
              r_parity_err <= 1'b1;
            end else if (r_dat_f != PS2_STOP_BIT) begin
              r_framing_err <= 1'b1;
            end else begin
              r_push_req  <= 1'b1;
              r_push_data <= r_shift;
            end
          end else if (w_to_hit) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Consumer handshake: a byte transfers in every cycle where valid_out and ready_in are both
  // high; ready_in without valid_out does nothing, and valid_out never drops without a pop.
  logic w_fifo_full, w_fifo_empty, w_pop;
  logic r_overflow_err;

  assign valid_out = ~w_fifo_empty;
  assign w_pop     = valid_out & ready_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_overflow_err <= 1'b0;
    else if (sync_reset) r_overflow_err <= 1'b0;
    else                 r_overflow_err <= r_push_req & w_fifo_full & ~w_pop;
  end

  ps2_sync_fifo #(
    .WIDTH (PS2_FRAME_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_clr   (sync_reset),
    .i_push  (r_push_req),
    .i_din   (r_push_data),
    .i_pop   (w_pop),
    .o_dout  (data_out),
    .o_count (fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign parity_err   = r_parity_err;
  assign framing_err  = r_framing_err;
  assign timeout_err  = r_timeout_err;
  assign overflow_err = r_overflow_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Directed bench for ps2_rx_buffered: frames are driven on the pins, accepted bytes are queued
// as expectations and a negedge monitor checks every pop and counts error pulses.
module tb_ps2_rx_buffered;
  import ps2_rx_buffered_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int TO    = 200;
  localparam int QTR   = 10;  // quarter of a PS/2 bit period, in clk cycles

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sync_reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic ready_in = 1'b0;
  logic [7:0]    data_out;
  logic          valid_out;
  logic [CW-1:0] fifo_count;
  logic          parity_err, framing_err, timeout_err, overflow_err;
  ps2_state_t    dbg_state;

  always #5 clk = ~clk;

  ps2_rx_buffered #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sync_reset   (sync_reset),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .fifo_count   (fifo_count),
    .parity_err   (parity_err),
    .framing_err  (framing_err),
    .timeout_err  (timeout_err),
    .overflow_err (overflow_err),
    .dbg_state    (dbg_state)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0, n_pop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (parity_err)   n_par++;
      if (framing_err)  n_frm++;
      if (timeout_err)  n_to++;
      if (overflow_err) n_ovf++;
      if (valid_out && ready_in) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %02h expected no byte", data_out);
        end else begin
          chk("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_dat = b;
    cyc(QTR);
    if (glitch) begin ps2_clk = 1'b0; cyc(1); ps2_clk = 1'b1; end
    cyc(QTR);
    ps2_clk = 1'b0;
    cyc(QTR);
    if (glitch) begin ps2_clk = 1'b1; cyc(1); ps2_clk = 1'b0; end
    cyc(QTR);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                            input int nbits, input bit glitch);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], glitch);
    ps2_dat = 1'b1;
    cyc(30);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && fifo_count != '0; i++) cyc(1);
    chk(name, 32'(fifo_count), 32'd0);
  endtask

  task automatic chk_errs(input int p, input int f, input int t, input int o);
    chk("parity_pulses",   32'(n_par), 32'(p));
    chk("framing_pulses",  32'(n_frm), 32'(f));
    chk("timeout_pulses",  32'(n_to),  32'(t));
    chk("overflow_pulses", 32'(n_ovf), 32'(o));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_data"},  32'(data_out), 32'd0);
    chk({tag, "_errs"},  32'({parity_err, framing_err, timeout_err, overflow_err}), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, required completion before 600000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(5);
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    cyc(10);

    // single byte with consumer ready
    ready_in = 1'b1;
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    chk("t1_pops", 32'(n_pop), 32'd1);
    chk_errs(0, 0, 0, 0);

    // burst buffered behind a stalled consumer
    ready_in = 1'b0;
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    chk("t2_count1", 32'(fifo_count), 32'd1);
    chk("t2_head", 32'(data_out), 32'hF0);
    chk("t2_valid", 32'(valid_out), 32'd1);
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    chk("t2_count2", 32'(fifo_count), 32'd2);
    ready_in = 1'b1;
    drain("t2_drain");
    chk("t2_pops", 32'(n_pop), 32'd3);

    // parity error, then framing error
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    chk("t3_par_count", 32'(fifo_count), 32'd0);
    chk_errs(1, 0, 0, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
    chk("t3_frm_count", 32'(fifo_count), 32'd0);
    chk_errs(1, 1, 0, 0);
    chk("t3_pops", 32'(n_pop), 32'd3);

    // clock stops after D3, then a clean frame
    send_frame(8'h32, 1'b0, 1'b1, 5, 1'b0);
    cyc(2 * TO);
    chk_errs(1, 1, 1, 0);
    chk("t4_state", 32'(dbg_state), 32'(S_IDLE));
    exp_q.push_back(8'h32);
    send_frame(8'h32, 1'b0, 1'b1, 11, 1'b0);
    chk("t4_pops", 32'(n_pop), 32'd4);

    // overflow on the fifth byte into a depth-4 FIFO
    ready_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b0, 1'b1, 11, 1'b0);
    end
    chk("t5_count_full", 32'(fifo_count), 32'(DEPTH));
    chk("t5_head", 32'(data_out), 32'h01);
    chk_errs(1, 1, 1, 1);
    ready_in = 1'b1;
    drain("t5_drain");
    chk("t5_pops", 32'(n_pop), 32'd8);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // single-cycle glitches on ps2_clk
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, 11, 1'b1);
    chk("t6_glitch_pops", 32'(n_pop), 32'd9);

    // async reset mid-frame with a byte buffered
    ready_in = 1'b0;
    send_frame(8'h55, 1'b0, 1'b1, 11, 1'b0);
    chk("t6_count_pre", 32'(fifo_count), 32'd1);
    send_frame(8'h2A, 1'b0, 1'b1, 4, 1'b0);
    chk("t6_state_mid", 32'(dbg_state), 32'(S_DATA));
    reset_n = 1'b0;
    cyc(3);
    chk_idle_outputs("t6_reset");
    reset_n = 1'b1;
    cyc(10);
    ready_in = 1'b1;
    exp_q.push_back(8'h2A);
    send_frame(8'h2A, 1'b0, 1'b1, 11, 1'b0);
    chk("t6_pops", 32'(n_pop), 32'd10);

    // synchronous clear flushes the FIFO
    ready_in = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1, 11, 1'b0);
    chk("sync_count_pre", 32'(fifo_count), 32'd1);
    sync_reset = 1'b1;
    cyc(1);
    sync_reset = 1'b0;
    chk("sync_count", 32'(fifo_count), 32'd0);
    chk("sync_valid", 32'(valid_out), 32'd0);
    ready_in = 1'b1;
    cyc(10);
    chk("sync_pops", 32'(n_pop), 32'd10);
    chk_errs(1, 1, 1, 1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
